// File: rtl/approx_mac_sequencer.sv
// approx_mac_sequencer
//   Feeds a job of operand pairs, one per cycle, into an external purely
//   combinational 8x8 approximate multiplier. It sums the returned products
//   into an accumulator and presents the job total on a valid/ready port.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, len            job request and pair count (sampled in IDLE only)
//   in_valid/in_ready     operand pair handshake, operands on in_a/in_b
//   mult_a, mult_b        registered operands driven to the multiplier
//   mult_p                product returned combinationally by the multiplier
//   out_valid/out_ready   result handshake, result on out_acc
//   overflow              sticky carry-out of any accumulation in the job
//   busy                  high in every state except IDLE
module approx_mac_sequencer #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mult_a,
  output logic [7:0]       mult_b,
  input  logic [15:0]      mult_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [7:0]         mult_a_q, mult_a_d;
  logic [7:0]         mult_b_q, mult_b_d;
  logic               p_v_q, p_v_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic               accept_c;
  logic [SUM_W-1:0]   sum_c;

  // in_ready_q mirrors state_q == S_RUN, so this is the pair handshake
  assign accept_c = in_valid && in_ready_q;
  // Extra top bit of the sum is the carry-out used for the sticky flag
  assign sum_c    = {1'b0, acc_q} + SUM_W'(mult_p);

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    p_v_d    = accept_c;
    acc_d    = p_v_q ? sum_c[ACC_W-1:0] : acc_q;
    ovf_d    = ovf_q | (p_v_q & sum_c[ACC_W]);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            rem_d   = len;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (accept_c) begin
          mult_a_d = in_a;
          mult_b_d = in_b;
          rem_d    = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // last product is being added on this edge
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake/status outputs are registered from the next state
    in_ready_d  = (state_d == S_RUN);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      p_v_q       <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      p_v_q       <= p_v_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_approx_mac_sequencer.sv
// Testbench for approx_mac_sequencer: a 24-bit and a 16-bit accumulator
// instance run the same jobs; table vectors, corner sequences and random
// jobs are checked against expected sums.
module tb_approx_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_ready = 1'b0;
  logic        approx_mode = 1'b0;

  logic        in_ready, out_valid, overflow, busy;
  logic [7:0]  mult_a, mult_b;
  logic [15:0] mult_p;
  logic [23:0] out_acc;

  logic        in_ready16, out_valid16, overflow16, busy16;
  logic [7:0]  mult_a16, mult_b16;
  logic [15:0] mult_p16;
  logic [15:0] out_acc16;

  int n_tests = 0;
  int n_fail  = 0;
  int pa[16];
  int pb[16];

  always #5 clk = ~clk;

  // Multiplier stub: exact, or an approximation dropping the low nibble
  function automatic logic [15:0] mul(input int a, input int b, input logic ap);
    logic [15:0] p;
    p = 16'(a * b);
    return ap ? (p & 16'hFFF0) : p;
  endfunction

  assign mult_p   = mul(int'(mult_a), int'(mult_b), approx_mode);
  assign mult_p16 = mul(int'(mult_a16), int'(mult_b16), approx_mode);

  approx_mac_sequencer #(.ACC_W(24), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .overflow(overflow), .busy(busy)
  );

  approx_mac_sequencer #(.ACC_W(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .mult_a(mult_a16), .mult_b(mult_b16), .mult_p(mult_p16),
    .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16),
    .overflow(overflow16), .busy(busy16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One full job using pa/pb; gap<0 means random 0..2 idle cycles per pair
  task automatic run_job(input int L, input int gap, input int ordly,
                         input logic [31:0] e24, input logic [31:0] o24,
                         input logic [31:0] e16, input logic [31:0] o16);
    int g;
    @(negedge clk);
    start = 1'b1;
    len   = 8'(L);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < L; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        @(negedge clk);
        if (i > 0) begin
          chk("gap_hold_a", 32'(mult_a), 32'(pa[i-1]));
          chk("gap_hold_b", 32'(mult_b), 32'(pb[i-1]));
        end
      end
      in_valid = 1'b1;
      in_a     = 8'(pa[i]);
      in_b     = 8'(pb[i]);
      chk("in_ready_run", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("mult_a_load", 32'(mult_a), 32'(pa[i]));
      chk("mult_b_load", 32'(mult_b), 32'(pb[i]));
    end
    if (L > 0) begin
      // DRAIN cycle: offered pair must be ignored
      in_valid = 1'b1;
      in_a     = 8'(pa[L-1] ^ 8'h5A);
      in_b     = 8'(pb[L-1] ^ 8'hA5);
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("done_mult_a_hold", 32'(mult_a), 32'(pa[L-1]));
    end
    chk("out_valid_latency", 32'(out_valid), 32'd1);
    chk("out_acc", 32'(out_acc), e24);
    chk("overflow", 32'(overflow), o24);
    chk("out_acc16", 32'(out_acc16), e16);
    chk("overflow16", 32'(overflow16), o16);
    chk("busy_done", 32'(busy), 32'd1);
    for (int k = 0; k < ordly; k++) @(negedge clk);
    chk("out_valid_held", 32'(out_valid), 32'd1);
    chk("out_acc_held", 32'(out_acc), e24);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_clear", 32'(out_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("out_acc_after", 32'(out_acc), e24);
    chk("overflow_after", 32'(overflow), o24);
  endtask

  typedef struct {
    int               len;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    int               gap;
    logic [31:0]      e24;
    logic [31:0]      o24;
    logic [31:0]      e16;
    logic [31:0]      o16;
  } vec_t;

  vec_t vecs[4];

  initial begin
    longint total;
    int     L;

    vecs[0] = '{4, {4{8'd255}}, {4{8'd255}}, 0, 32'd260100, 32'd0, 32'd63492, 32'd1};
    vecs[1] = '{2, {4{8'd255}}, {4{8'd255}}, 0, 32'd130050, 32'd0, 32'd64514, 32'd1};
    vecs[2] = '{3, {8'd0, 8'd16, 8'd0, 8'd3}, {8'd0, 8'd16, 8'd9, 8'd5}, 2,
                32'd271, 32'd0, 32'd271, 32'd0};
    vecs[3] = '{1, {8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd0, 8'd6}, 1,
                32'd42, 32'd0, 32'd42, 32'd0};

    // Reset values
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_acc", 32'(out_acc), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mult_a", 32'(mult_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors with the exact multiplier
    approx_mode = 1'b0;
    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].len; i++) begin
        pa[i] = int'(vecs[v].a[i]);
        pb[i] = int'(vecs[v].b[i]);
      end
      run_job(vecs[v].len, vecs[v].gap, 1, vecs[v].e24, vecs[v].o24,
              vecs[v].e16, vecs[v].o16);
    end

    // Overflow from the 16-bit job must clear on the next start; len=0 job
    pa[0] = 255; pb[0] = 255; pa[1] = 255; pb[1] = 255;
    run_job(2, 0, 0, 32'd130050, 32'd0, 32'd64514, 32'd1);
    @(negedge clk);
    start = 1'b1;
    len   = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_out_valid", 32'(out_valid), 32'd1);
    chk("len0_out_acc", 32'(out_acc), 32'd0);
    chk("len0_overflow16", 32'(overflow16), 32'd0);
    chk("len0_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      start    = 1'b1;
      len      = 8'd3;
      in_valid = 1'b1;
      in_a     = 8'd99;
      in_b     = 8'd99;
      @(negedge clk);
      chk("len0_hold_valid", 32'(out_valid), 32'd1);
      chk("len0_hold_acc", 32'(out_acc), 32'd0);
      chk("len0_hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd2;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    chk("hs_start_valid", 32'(out_valid), 32'd0);
    chk("hs_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("hs_start_idle", 32'(busy), 32'd0);

    // Reset asserted mid-RUN after 2 of 5 accepts
    start = 1'b1;
    len   = 8'd5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_a = 8'd15; in_b = 8'd15;
    @(negedge clk);
    in_a = 8'd20; in_b = 8'd20;
    @(negedge clk);
    chk("mid_acc_partial", 32'(out_acc), 32'd225);
    in_a = 8'd30; in_b = 8'd30;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_acc", 32'(out_acc), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mult_a", 32'(mult_a), 32'd0);
    chk("mid_rst_mult_b", 32'(mult_b), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    pa[0] = 7; pb[0] = 6;
    run_job(1, 0, 0, 32'd42, 32'd0, 32'd42, 32'd0);

    // Random jobs against a running-sum model
    for (int j = 0; j < 12; j++) begin
      L = int'($urandom_range(1, 12));
      approx_mode = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (j == 0) L = 8;
      total = 0;
      for (int i = 0; i < L; i++) begin
        pa[i] = int'($urandom_range(0, 255));
        pb[i] = int'($urandom_range(0, 255));
        total += longint'(mul(pa[i], pb[i], approx_mode));
      end
      run_job(L, -1, int'($urandom_range(0, 3)),
              32'(total % 64'd16777216), 32'(total >= 64'd16777216),
              32'(total % 64'd65536), 32'(total >= 64'd65536));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
